debounce_multi_fsm: RTL and testbench

- N-channel switch debouncer.
- Each channel has its own input synchronizer, a four-state FSM and a stability counter.
- Each channel produces a Moore debounced level and Mealy one-cycle rise/fall ticks.
- Sits between raw board inputs (buttons, slide switches) and control logic. It replaces per-input single-channel debouncers and adds a fall tick, a synchronous clear and a busy flag.

---
 rtl/debounce_multi_fsm.sv | 122 ++++++++++++
 tb/tb_debounce_multi_fsm.sv | 126 ++++++++++++
 2 files changed

// File: rtl/debounce_multi_fsm.sv
// N-channel switch debouncer: a per-channel synchronizer, a four-state FSM and a stability
// down-counter, producing a Moore debounced level plus Mealy rise/fall ticks.
module debounce_multi_fsm #(
  parameter int N           = 4,
  parameter int STABLE_CYC  = 1000000,
  parameter int CNT_W       = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic [N-1:0] sw,
  output logic [N-1:0] db_level,
  output logic [N-1:0] rise_tick,
  output logic [N-1:0] fall_tick,
  output logic         busy
);

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STABLE_CYC - 1);

  logic [N-1:0] busy_vec;

  assign busy = |busy_vec;

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sw_s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_c, rise_c, fall_c, busy_c;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, which is what makes the shift chain work.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync_q  <= '0;
        state_q <= ZERO;
        cnt_q   <= '0;
      end else begin
        sync_q  <= {sync_q[SYNC_STAGES-2:0], sw[i]};
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign sw_s = sync_q[SYNC_STAGES-1];

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_c = 1'b0;
      rise_c  = 1'b0;
      fall_c  = 1'b0;
      busy_c  = 1'b0;
      case (state_q)
        ZERO: begin
          if (sw_s) begin
            state_d = WAIT1;
            cnt_d   = RELOAD;
          end
        end
        WAIT1: begin
          busy_c = 1'b1;
          if (!sw_s) begin
            state_d = ZERO;
          end else if (cnt_q == '0) begin
            state_d = ONE;
            rise_c  = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ONE: begin
          level_c = 1'b1;
          if (!sw_s) begin
            state_d = WAIT0;
            cnt_d   = RELOAD;
          end
        end
        WAIT0: begin
          level_c = 1'b1;
          busy_c  = 1'b1;
          if (sw_s) begin
            state_d = ONE;
          end else if (cnt_q == '0) begin
            state_d = ZERO;
            fall_c  = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = ZERO;
          cnt_d   = '0;
        end
      endcase

      // Clear overrides everything, including a count expiring this cycle.
      if (clr) begin
        state_d = ZERO;
        cnt_d   = '0;
        rise_c  = 1'b0;
        fall_c  = 1'b0;
      end
    end

    assign db_level[i]  = level_c;
    assign rise_tick[i] = rise_c;
    assign fall_tick[i] = fall_c;
    assign busy_vec[i]  = busy_c;
  end

endmodule

// File: tb/tb_debounce_multi_fsm.sv
// Scoreboard bench for debounce_multi_fsm: stimulus pushes hand-derived expected outputs
// per cycle, a negedge monitor pops and compares them.
module tb_debounce_multi_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clr = 1'b0;
  logic [3:0] sw = 4'b0000;
  logic [3:0] db_level, rise_tick, fall_tick;
  logic       busy;

  typedef struct {
    logic [3:0] db;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       busy;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  debounce_multi_fsm #(
    .N(4), .STABLE_CYC(4), .CNT_W(3), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset), .clr(clr), .sw(sw),
    .db_level(db_level), .rise_tick(rise_tick), .fall_tick(fall_tick), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the DUT presents a full output vector every cycle; sample mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check({mon_e.name, ".db_level"},  db_level,        mon_e.db);
      check({mon_e.name, ".rise_tick"}, rise_tick,       mon_e.rise);
      check({mon_e.name, ".fall_tick"}, fall_tick,       mon_e.fall);
      check({mon_e.name, ".busy"},      {3'b000, busy},  {3'b000, mon_e.busy});
    end
  end

  task automatic step(input logic [3:0] s, input logic c, input logic r,
                      input logic [3:0] edb, input logic [3:0] er, input logic [3:0] ef,
                      input logic eb, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    sw    = s;
    clr   = c;
    reset = r;
    e.db = edb; e.rise = er; e.fall = ef; e.busy = eb; e.name = name;
    sb_q.push_back(e);
  endtask

  // Clean change applied in cycle k=0 and held: WAIT for k=3..6, tick at k=6, level from k=7.
  task automatic transition(input logic [3:0] s, input logic [3:0] db_before,
                            input logic [3:0] chg, input bit rising, input string name);
    logic [3:0] db_after;
    db_after = rising ? (db_before | chg) : (db_before & ~chg);
    for (int k = 0; k < 9; k++) begin
      step(s, 1'b0, 1'b0,
           (k >= 7) ? db_after : db_before,
           (rising && k == 6) ? chg : 4'b0000,
           (!rising && k == 6) ? chg : 4'b0000,
           (k >= 3 && k <= 6), name);
    end
  endtask

  initial begin
    step(4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, "reset");
    step(4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, "reset");
    for (int k = 0; k < 10; k++)
      step(4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "idle");

    transition(4'b0001, 4'b0000, 4'b0001, 1'b1, "ch0_rise");

    // Channel 1 high for 3 raw cycles only: WAIT1 for k=3..5, then back to ZERO silently.
    for (int k = 0; k < 8; k++)
      step((k < 3) ? 4'b0011 : 4'b0001, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000,
           (k >= 3 && k <= 5), "ch1_bounce");

    transition(4'b0101, 4'b0001, 4'b0100, 1'b1, "ch2_rise");
    transition(4'b0001, 4'b0101, 4'b0100, 1'b0, "ch2_fall");
    transition(4'b0000, 4'b0001, 4'b0001, 1'b0, "ch0_fall");
    transition(4'b1111, 4'b0000, 4'b1111, 1'b1, "all_rise");
    transition(4'b0000, 4'b1111, 4'b1111, 1'b0, "all_fall");

    // clr in the cycle the rise would fire; synchronizer survives so a fresh WAIT1 follows.
    for (int k = 0; k < 13; k++)
      step(4'b0001, (k == 6), 1'b0,
           (k >= 12) ? 4'b0001 : 4'b0000,
           (k == 11) ? 4'b0001 : 4'b0000,
           4'b0000,
           ((k >= 3 && k <= 6) || (k >= 8 && k <= 11)), "clr_kill");

    // Reset while channel 1 sits in WAIT1; everything restarts including synchronizers.
    for (int k = 0; k < 14; k++)
      step(4'b0011, 1'b0, (k == 5),
           (k < 5) ? 4'b0001 : ((k >= 13) ? 4'b0011 : 4'b0000),
           (k == 12) ? 4'b0011 : 4'b0000,
           4'b0000,
           ((k >= 3 && k <= 4) || (k >= 9 && k <= 12)), "reset_mid");

    for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
